// File: rtl/neurex_load_ctrl.sv
// neurex_load_ctrl: operand load sequencer for the NEUREX systolic array.
// Accepts a GEMM job (num_in x num_common x num_out) and streams the input
// and weight buffers out as two independent address streams, four operands
// per beat. Once both streams have drained, the controller waits for the
// array pipeline to empty and then pulses done.
// Optional feature: define NEUREX_LOAD_CTRL_PERF_EN to add the stall_cnt
// performance counter output.
module neurex_load_ctrl #(
  parameter int SYS_ROW    = 4,
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int IN_BASE    = 0,
  parameter int W_BASE     = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] num_in,
  input  logic [DATA_WIDTH-1:0] num_common,
  input  logic [DATA_WIDTH-1:0] num_out,
  output logic                  in_en,
  input  logic                  in_rdy,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  w_en,
  input  logic                  w_rdy,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef NEUREX_LOAD_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int CW        = 2 * DATA_WIDTH;
  localparam int DRAIN_LEN = SYS_ROW + SYS_COL;
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   in_prod, w_prod, in_beats, w_beats;
  logic [CW-1:0]   in_cnt, w_cnt, in_cnt_nxt, w_cnt_nxt;
  logic [DCW-1:0]  drain_cnt;
  logic            err_r;
  logic            start_ok, zero_dim, in_xfer, w_xfer;

  // Job acceptance, beat-count arithmetic and per-stream handshakes.
  // The +3 rounding is done as a shift plus a carry bit from the low bits so
  // the full-width product can never overflow the count register.
  always_comb begin
    start_ok   = (state == IDLE) && start;
    zero_dim   = (num_in == '0) || (num_common == '0) || (num_out == '0);
    in_prod    = CW'(num_in) * CW'(num_common);
    w_prod     = CW'(num_common) * CW'(num_out);
    in_beats   = (in_prod >> 2) + CW'(|in_prod[1:0]);
    w_beats    = (w_prod >> 2) + CW'(|w_prod[1:0]);
    in_xfer    = in_en && in_rdy;
    w_xfer     = w_en && w_rdy;
    in_cnt_nxt = in_xfer ? in_cnt - CW'(1) : in_cnt;
    w_cnt_nxt  = w_xfer ? w_cnt - CW'(1) : w_cnt;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = zero_dim ? DONE : LOAD;
      LOAD:  if (abort) state_nxt = IDLE;
             else if ((in_cnt_nxt == '0) && (w_cnt_nxt == '0)) state_nxt = DRAIN;
      DRAIN: if (abort) state_nxt = IDLE;
             else if (drain_cnt == DCW'(DRAIN_LEN - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; done/err are suppressed when the DONE cycle is aborted.
  always_comb begin
    in_en = (state == LOAD) && (in_cnt != '0);
    w_en  = (state == LOAD) && (w_cnt != '0);
    busy  = (state != IDLE);
    done  = (state == DONE) && !abort;
    err   = (state == DONE) && err_r && !abort;
  end

  // Stream counters and addresses; a new job restarts both streams at base.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt    <= '0;
      w_cnt     <= '0;
      in_addr   <= ADDR_WIDTH'(IN_BASE);
      w_addr    <= ADDR_WIDTH'(W_BASE);
      drain_cnt <= '0;
      err_r     <= 1'b0;
    end else if (start_ok) begin
      in_cnt    <= zero_dim ? '0 : in_beats;
      w_cnt     <= zero_dim ? '0 : w_beats;
      in_addr   <= ADDR_WIDTH'(IN_BASE);
      w_addr    <= ADDR_WIDTH'(W_BASE);
      drain_cnt <= '0;
      err_r     <= zero_dim;
    end else begin
      if (in_xfer) begin
        in_cnt  <= in_cnt_nxt;
        in_addr <= in_addr + ADDR_WIDTH'(1);
      end
      if (w_xfer) begin
        w_cnt  <= w_cnt_nxt;
        w_addr <= w_addr + ADDR_WIDTH'(1);
      end
      if (abort && (state != IDLE)) begin
        in_cnt <= '0;
        w_cnt  <= '0;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
    end
  end

`ifdef NEUREX_LOAD_CTRL_PERF_EN
  // Saturating count of LOAD cycles where an active stream is back-pressured.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == LOAD) && ((in_en && !in_rdy) || (w_en && !w_rdy))
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_neurex_load_ctrl.sv
// Directed testbench for neurex_load_ctrl (default parameters).
// Cycle c of a test is the window after the c-th rising edge following the
// cycle in which start was driven (cycle 0). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_neurex_load_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_in = '0, num_common = '0, num_out = '0;
  logic        in_rdy = 1'b1, w_rdy = 1'b1;
  logic        in_en, w_en, busy, done, err;
  logic [15:0] in_addr, w_addr;
`ifdef NEUREX_LOAD_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] act, exp;
  int in_xfers, w_xfers;

  neurex_load_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .num_in(num_in), .num_common(num_common), .num_out(num_out),
    .in_en(in_en), .in_rdy(in_rdy), .in_addr(in_addr),
    .w_en(w_en), .w_rdy(w_rdy), .w_addr(w_addr),
    .busy(busy), .done(done), .err(err)
`ifdef NEUREX_LOAD_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    start = 1'b1; num_in = a; num_common = b; num_out = c;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #2;
    act = {in_en, w_en, busy, done, err};
    vectors++;
    if (act !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset flags got %b exp 00000", act);
    end
    vectors++;
    if (in_addr !== 16'd0 || w_addr !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset addr got %0d/%0d exp 0/0", in_addr, w_addr);
    end
    tick;
    rstn = 1'b1;
    @(negedge clk);
    act = {in_en, w_en, busy, done, err};
    vectors++;
    if (act !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release flags got %b exp 00000", act);
    end
  endtask

  task automatic test_basic;
    tick;
    launch(16'd8, 16'd8, 16'd16);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic c0 busy got %b exp 0", busy);
    end
    for (int c = 1; c <= 43; c++) begin
      tick;
      start = 1'b0;
      if (c == 5)  launch(16'd1, 16'd1, 16'd1);
      if (c == 41) launch(16'd8, 16'd8, 16'd16);
      @(negedge clk);
      exp = {c <= 16, c <= 32, c <= 41, c == 41, 1'b0};
      act = {in_en, w_en, busy, done, err};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL basic flags c=%0d got %b exp %b", c, act, exp);
      end
      if (c <= 16) begin
        vectors++;
        if (in_addr !== 16'(c - 1)) begin
          miscompares++;
          $display("[TB] FAIL basic in_addr c=%0d got %0d exp %0d", c, in_addr, c - 1);
        end
      end
      if (c <= 32) begin
        vectors++;
        if (w_addr !== 16'(c - 1)) begin
          miscompares++;
          $display("[TB] FAIL basic w_addr c=%0d got %0d exp %0d", c, w_addr, c - 1);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_stall;
    int ew;
    tick;
    launch(16'd8, 16'd8, 16'd16);
    w_xfers = 0;
    for (int c = 1; c <= 48; c++) begin
      tick;
      start = 1'b0;
      w_rdy = !(c >= 5 && c <= 9);
      @(negedge clk);
      if (w_en && w_rdy) w_xfers++;
      exp = {c <= 16, c <= 37, c <= 46, c == 46, 1'b0};
      act = {in_en, w_en, busy, done, err};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL stall flags c=%0d got %b exp %b", c, act, exp);
      end
      if (c <= 37) begin
        ew = (c < 5) ? c - 1 : (c <= 9) ? 4 : c - 6;
        vectors++;
        if (w_addr !== 16'(ew)) begin
          miscompares++;
          $display("[TB] FAIL stall w_addr c=%0d got %0d exp %0d", c, w_addr, ew);
        end
      end
`ifdef NEUREX_LOAD_CTRL_PERF_EN
      if (c >= 47) begin
        vectors++;
        if (stall_cnt !== 32'd5) begin
          miscompares++;
          $display("[TB] FAIL stall_cnt c=%0d got %0d exp 5", c, stall_cnt);
        end
      end
`endif
    end
    w_rdy = 1'b1;
    vectors++;
    if (w_xfers != 32) begin
      miscompares++;
      $display("[TB] FAIL stall w_xfers got %0d exp 32", w_xfers);
    end
  endtask

  task automatic test_zero_dim;
    tick;
    launch(16'd8, 16'd8, 16'd0);
    for (int c = 1; c <= 3; c++) begin
      tick;
      start = 1'b0;
      @(negedge clk);
      exp = {1'b0, 1'b0, c == 1, c == 1, c == 1};
      act = {in_en, w_en, busy, done, err};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL zero_dim flags c=%0d got %b exp %b", c, act, exp);
      end
`ifdef NEUREX_LOAD_CTRL_PERF_EN
      if (c == 1) begin
        vectors++;
        if (stall_cnt !== 32'd0) begin
          miscompares++;
          $display("[TB] FAIL zero_dim stall_cnt got %0d exp 0", stall_cnt);
        end
      end
`endif
    end
  endtask

  task automatic test_small;
    tick;
    launch(16'd3, 16'd1, 16'd3);
    in_xfers = 0;
    w_xfers = 0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      start = 1'b0;
      @(negedge clk);
      if (in_en && in_rdy) in_xfers++;
      if (w_en && w_rdy) w_xfers++;
      exp = {c == 1, c == 1, c <= 10, c == 10, 1'b0};
      act = {in_en, w_en, busy, done, err};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL small flags c=%0d got %b exp %b", c, act, exp);
      end
    end
    vectors++;
    if (in_xfers != 1 || w_xfers != 1) begin
      miscompares++;
      $display("[TB] FAIL small xfers got %0d/%0d exp 1/1", in_xfers, w_xfers);
    end
  endtask

  task automatic test_abort;
    int k;
    tick;
    launch(16'd8, 16'd8, 16'd16);
    for (int c = 1; c <= 24; c++) begin
      tick;
      start = 1'b0;
      abort = (c == 10) || (c == 12);
      if (c == 12) launch(16'd3, 16'd1, 16'd3);
      @(negedge clk);
      k = c - 12;
      if (c <= 10)      exp = 5'b11100;
      else if (c <= 12) exp = 5'b00000;
      else              exp = {k == 1, k == 1, k <= 10, k == 10, 1'b0};
      act = {in_en, w_en, busy, done, err};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL abort flags c=%0d got %b exp %b", c, act, exp);
      end
      if (c == 13) begin
        vectors++;
        if (in_addr !== 16'd0 || w_addr !== 16'd0) begin
          miscompares++;
          $display("[TB] FAIL abort restart addr got %0d/%0d exp 0/0", in_addr, w_addr);
        end
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_abort_done;
    tick;
    launch(16'd3, 16'd1, 16'd3);
    for (int c = 1; c <= 11; c++) begin
      tick;
      start = 1'b0;
      abort = (c == 10);
      @(negedge clk);
      exp = {c == 1, c == 1, c <= 10, 1'b0, 1'b0};
      act = {in_en, w_en, busy, done, err};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL abort_done flags c=%0d got %b exp %b", c, act, exp);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid;
    tick;
    launch(16'd8, 16'd8, 16'd16);
    for (int c = 1; c <= 20; c++) begin
      tick;
      start = 1'b0;
      if (c == 6) rstn = 1'b1;
      if (c == 5) begin
        rstn = 1'b0;
        #1;
        act = {in_en, w_en, busy, done, err};
        vectors++;
        if (act !== 5'b0 || in_addr !== 16'd0 || w_addr !== 16'd0) begin
          miscompares++;
          $display("[TB] FAIL reset_mid async got %b %0d/%0d exp 00000 0/0", act, in_addr, w_addr);
        end
      end
      @(negedge clk);
      exp = (c < 5) ? 5'b11100 : 5'b00000;
      act = {in_en, w_en, busy, done, err};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL reset_mid flags c=%0d got %b exp %b", c, act, exp);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero_dim;
    test_small;
    test_abort;
    test_abort_done;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neurex_load_ctrl.md
NEUREX_LOAD_CTRL -- requirements
Module: neurex_load_ctrl

Interface
REQ-001 Parameter SYS_ROW, default 4, systolic array rows.
REQ-002 Parameter SYS_COL, default 4, systolic array columns.
REQ-003 Parameter DATA_WIDTH, default 16, dimension operand width.
REQ-004 Parameter ADDR_WIDTH, default 16, fetch address width.
REQ-005 Parameter IN_BASE, default 0, first input-buffer address.
REQ-006 Parameter W_BASE, default 0, first weight-buffer address.
REQ-007 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-008 Port rstn, input, 1, asynchronous active-low reset.
REQ-009 Port start, input, 1, job request, sampled only in IDLE.
REQ-010 Port abort, input, 1, cancels the current job.
REQ-011 Ports num_in, num_common, num_out, input, DATA_WIDTH each, GEMM dimensions, captured on accepted start.
REQ-012 Port in_en, output, 1, input-stream beat valid.
REQ-013 Port in_rdy, input, 1, input-stream beat ready.
REQ-014 Port in_addr, output, ADDR_WIDTH, input-buffer address of the current beat.
REQ-015 Ports w_en output 1, w_rdy input 1, w_addr output ADDR_WIDTH: weight-stream equivalents of in_en/in_rdy/in_addr.
REQ-016 Port busy, output, 1, high in any state other than IDLE.
REQ-017 Ports done and err, output, 1 each, single-cycle completion and error pulses.

Function
REQ-018 States SHALL be IDLE, LOAD, DRAIN and DONE.
REQ-019 IDLE with start=1 SHALL capture dimensions and compute in_beats = ceil(num_in*num_common/4) and w_beats = ceil(num_common*num_out/4) at 2*DATA_WIDTH width, without overflow.
REQ-020 If any captured dimension is 0, the next state SHALL be DONE with err=1 and done=1, and no beats SHALL be issued.
REQ-021 Otherwise the next state SHALL be LOAD, with in_en and w_en both asserted in the first LOAD cycle.
REQ-022 A beat SHALL transfer on a cycle with en=1 and rdy=1.
REQ-023 After each transfer the stream's address SHALL increment by 1, wrapping modulo 2^ADDR_WIDTH, and its remaining count SHALL decrement.
REQ-024 en SHALL stay high with address stable until rdy=1.
REQ-025 The two streams SHALL progress independently.
REQ-026 Each stream's en SHALL deassert the cycle after its last transfer and stay low for the rest of the job.
REQ-027 LOAD SHALL go to DRAIN the cycle after both counts reach 0, including when both streams finish on the same cycle.
REQ-028 DRAIN SHALL last exactly SYS_ROW+SYS_COL cycles, then go to DONE.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 start in the same cycle that DONE returns to IDLE SHALL be ignored.
REQ-032 abort=1 in LOAD, DRAIN or DONE SHALL force IDLE the next cycle, with en low and no done pulse; abort has priority over all other transitions.
REQ-033 abort in IDLE SHALL be ignored.

Reset
REQ-034 rstn=0 SHALL immediately, regardless of clk, force IDLE and set in_en, w_en, busy, done and err to 0, in_addr to IN_BASE, w_addr to W_BASE, and counts to 0.
REQ-035 Reset mid-job SHALL discard the job, and no done pulse SHALL follow reset release.

Configuration
REQ-036 With NEUREX_LOAD_CTRL_PERF_EN defined, an output stall_cnt (32 bits) SHALL count cycles in LOAD where some en=1 and its rdy=0, saturating at all-ones.
REQ-037 stall_cnt SHALL clear on an accepted start and on reset, and hold its value in IDLE.
REQ-038 Without NEUREX_LOAD_CTRL_PERF_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 Start in cycle 0 with 8/8/16, in_rdy=w_rdy=1 -> in_en high for cycles 1-16 with in_addr 0..15; w_en high for cycles 1-32 with w_addr 0..31; DRAIN in cycles 33-40; done=1 in cycle 41; busy low from cycle 42.
REQ-040 Same job, w_rdy low in cycles 5-9 -> w_addr holds 4 for those cycles; 32 weight transfers total; done in cycle 46; stall_cnt=5 when the macro is defined.
REQ-041 Start with num_out=0 -> done=1 and err=1 in cycle 1; in_en and w_en never asserted.
REQ-042 Start with 3/1/3 -> exactly 1 input beat and 1 weight beat; done in cycle 10.
REQ-043 abort in cycle 10 of the 8/8/16 job -> IDLE in cycle 11; both en low; no done; a new start is accepted in cycle 12 with addresses restarting at the base values.
REQ-044 rstn low for one cycle mid-LOAD -> outputs take reset values immediately; no done after release.
